rr_arb_mux_4_1: RTL and testbench

//   Arbitrating front end for the 4:1 data mux.
//   - Four valid/ready input channels compete for one output.
//   - A round-robin arbiter produces the 2-bit select.
//   - Datapath is WIDTH/2 instances of mux_4_1_width_2, all driven by that select.
//   - A one-entry output register slice feeds the downstream consumer over valid/ready.

---
 rtl/rr_arb_mux_4_1.sv | 102 ++++++++++
 tb/tb_rr_arb_mux_4_1.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbitrated 4:1 mux front end. Four valid/ready channels share one
// output through a 2-bit-slice mux datapath and a one-entry output register slice.

module mux_4_1_width_2 (
  input  logic [1:0] d0,
  input  logic [1:0] d1,
  input  logic [1:0] d2,
  input  logic [1:0] d3,
  input  logic [1:0] sel,
  output logic [1:0] y
);

  always_comb begin
    unique case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

module rr_arb_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel
);

  localparam int SLICES = WIDTH / 2;

  logic [1:0]       last;
  logic [1:0]       grant;
  logic             load;
  logic             fire;
  logic [WIDTH-1:0] mux_y;

  // Round-robin pick: channel ptr+1 has highest priority, ptr itself the lowest.
  // Scanning from lowest to highest priority lets the last hit win.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  // NOTE: every signal assigned in always_comb gets a value on all paths, so no latch is inferred.
  always_comb begin
    load     = !out_valid || out_ready;
    grant    = rr_pick(in_valid, last);
    in_ready = 4'b0000;
    if (rst_n && load && (|in_valid)) in_ready[grant] = 1'b1;
    fire     = |(in_valid & in_ready);
  end

  for (genvar g = 0; g < SLICES; g++) begin : g_slice
    mux_4_1_width_2 u_mux (
      .d0  (in_data0[2*g +: 2]),
      .d1  (in_data1[2*g +: 2]),
      .d2  (in_data2[2*g +: 2]),
      .d3  (in_data3[2*g +: 2]),
      .sel (grant),
      .y   (mux_y[2*g +: 2])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      last      <= 2'd3;
    end else if (load) begin
      if (fire) begin
        out_valid <= 1'b1;
        out_data  <= mux_y;
        out_sel   <= grant;
        last      <= grant;
      end else begin
        // Slice drains with nothing to refill it; data, sel and pointer hold.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed bench for rr_arb_mux_4_1: a table of per-cycle vectors followed by a
// hand-written per-channel data sweep with varying data patterns.

module tb_rr_arb_mux_4_1;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [WIDTH-1:0] in_data0;
  logic [WIDTH-1:0] in_data1;
  logic [WIDTH-1:0] in_data2;
  logic [WIDTH-1:0] in_data3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;

  int n_tests;
  int n_failed;

  rr_arb_mux_4_1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] valid;
    logic       ready;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [3:0] exp_od;
    logic [1:0] exp_os;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [3:0] v, input logic o_r,
                              input logic [3:0] rdy, input logic ov,
                              input logic [3:0] od, input logic [1:0] os);
    vec_t e;
    e.rst_n = r; e.valid = v; e.ready = o_r;
    e.exp_rdy = rdy; e.exp_ov = ov; e.exp_od = od; e.exp_os = os;
    tbl.push_back(e);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs mid-cycle, check in_ready before the edge, outputs after it.
  task automatic step(input int idx, input vec_t e);
    @(negedge clk);
    rst_n     = e.rst_n;
    in_valid  = e.valid;
    out_ready = e.ready;
    #1;
    check($sformatf("v%0d in_ready", idx), {4'd0, in_ready}, {4'd0, e.exp_rdy});
    @(posedge clk);
    #1;
    check($sformatf("v%0d out_valid", idx), {7'd0, out_valid}, {7'd0, e.exp_ov});
    check($sformatf("v%0d out_data", idx), {4'd0, out_data}, {4'd0, e.exp_od});
    check($sformatf("v%0d out_sel", idx), {6'd0, out_sel}, {6'd0, e.exp_os});
  endtask

  initial begin
    logic [WIDTH-1:0] pat [4];
    logic [WIDTH-1:0] expd;

    n_tests   = 0;
    n_failed  = 0;
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    in_data0  = 4'hA;
    in_data1  = 4'hB;
    in_data2  = 4'hC;
    in_data3  = 4'hD;

    //   rst   valid    rdy   exp_rdy  ov    od    os
    add(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0);
    add(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0);
    // All four requesting, consumer always ready: rotation 0,1,2,3,0.
    add(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0);
    add(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);
    add(1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2);
    add(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3);
    add(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0);
    // Backpressure for three cycles, then release grants channel 1.
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0);
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0);
    add(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0);
    add(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);
    // Only channel 2 valid.
    add(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2);
    add(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2);
    add(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 4'hC, 2'd2);
    // Move pointer to 3, then 1010 gives 1 and then 3.
    add(1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3);
    add(1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);
    add(1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd3);
    // No request: slice empties, data and sel hold.
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'hD, 2'd3);
    add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'hD, 2'd3);
    // Empty slice loads even with out_ready low, then holds.
    add(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'hC, 2'd2);
    add(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, 4'hC, 2'd2);
    // Load a beat, stall, reset mid-operation, then channel 0 wins first.
    add(1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0);
    add(1'b1, 4'b0010, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0);
    add(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0);
    add(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0);
    add(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1);

    foreach (tbl[i]) step(i, tbl[i]);

    // Per-channel data sweep with distinct bit patterns to exercise every mux slice.
    // Pointer is 1 here; a lone requester is always granted regardless.
    for (int p = 0; p < 3; p++) begin
      for (int ch = 0; ch < 4; ch++) begin
        for (int j = 0; j < 4; j++) pat[j] = WIDTH'($urandom_range(0, 15));
        pat[ch] = (p == 0) ? 4'h5 : (p == 1) ? 4'hA : pat[ch];
        expd = pat[ch];
        @(negedge clk);
        in_data0  = pat[0];
        in_data1  = pat[1];
        in_data2  = pat[2];
        in_data3  = pat[3];
        in_valid  = 4'b0001 << ch;
        out_ready = 1'b1;
        #1;
        check($sformatf("sweep%0d ch%0d in_ready", p, ch), {4'd0, in_ready}, {4'd0, 4'b0001 << ch});
        @(posedge clk);
        #1;
        check($sformatf("sweep%0d ch%0d out_data", p, ch), {4'd0, out_data}, {4'd0, expd});
        check($sformatf("sweep%0d ch%0d out_sel", p, ch), {6'd0, out_sel}, 8'(ch));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
